// File: rtl/instruction_sequencer.sv
// Four-step instruction sequencer (fetch, immediate, read, write) with memory wait-state stretching,
// halt/resume control and a sticky bus error. Optional retire counter: INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN.
module instruction_sequencer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        resume,
    input  logic        mem_ready,
    input  logic        halt_request,
    input  logic        can_halt,
    input  logic        source_mem,
    input  logic        destination_mem,
    input  logic        write_enable,
    output logic [1:0]  step,
    output logic [1:0]  address_select,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_advance,
    output logic        halted,
    output logic        bus_error
`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_IMM    = 3'd2,
        S_READ   = 3'd3,
        S_WRITE  = 3'd4,
        S_HALTED = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_LIMIT - 1);

    state_t     r_state;
    logic [1:0] r_step;
    logic       r_halted;
    logic       r_bus_error;
    logic [3:0] r_wait;

    logic       w_mem_read;
    logic       w_mem_write;
    logic [1:0] w_addr_sel;
    logic       w_pc_advance;
    logic       w_halt;
    logic       w_strobe;
    logic       w_step_done;
    logic       w_wait_over;

    // Strobe, address-source and pc-advance decode from the current step and its inputs.
    always_comb begin
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_addr_sel   = 2'd0;
        w_pc_advance = 1'b0;
        w_halt       = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_addr_sel = 2'd0;
            end
            S_IMM: begin
                w_mem_read = 1'b1;
                w_addr_sel = 2'd1;
            end
            S_READ: begin
                w_addr_sel = 2'd2;
                w_halt     = halt_request & can_halt;
                w_mem_read = source_mem & ~w_halt;
            end
            S_WRITE: begin
                w_addr_sel   = 2'd3;
                w_mem_write  = destination_mem & write_enable;
                w_pc_advance = ~w_mem_write | mem_ready;
            end
            default: begin
                w_addr_sel = 2'd0;
            end
        endcase
        // mem_ready only counts while a strobe is out; unstrobed steps finish in one cycle.
        w_strobe    = w_mem_read | w_mem_write;
        w_step_done = ~w_strobe | mem_ready;
        w_wait_over = w_strobe & ~mem_ready & (r_wait == WAIT_LAST);
    end

    // Sequencer state, registered step/halted/bus_error and per-step wait counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_step      <= 2'd0;
            r_halted    <= 1'b0;
            r_bus_error <= 1'b0;
            r_wait      <= 4'd0;
        end else if (w_wait_over) begin
            r_state     <= S_ERROR;
            r_step      <= 2'd0;
            r_bus_error <= 1'b1;
            r_wait      <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_step  <= 2'd0;
                        r_wait  <= 4'd0;
                    end
                end
                S_FETCH: begin
                    if (w_step_done) begin
                        r_state <= S_IMM;
                        r_step  <= 2'd1;
                        r_wait  <= 4'd0;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_IMM: begin
                    if (w_step_done) begin
                        r_state <= S_READ;
                        r_step  <= 2'd2;
                        r_wait  <= 4'd0;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_READ: begin
                    if (w_halt) begin
                        r_state  <= S_HALTED;
                        r_step   <= 2'd0;
                        r_halted <= 1'b1;
                        r_wait   <= 4'd0;
                    end else if (w_step_done) begin
                        r_state <= S_WRITE;
                        r_step  <= 2'd3;
                        r_wait  <= 4'd0;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_WRITE: begin
                    if (w_step_done) begin
                        r_state <= run ? S_FETCH : S_IDLE;
                        r_step  <= 2'd0;
                        r_wait  <= 4'd0;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                S_HALTED: begin
                    if (resume) begin
                        r_state  <= S_IDLE;
                        r_halted <= 1'b0;
                    end
                end
                S_ERROR: begin
                    r_state <= S_ERROR;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_step   <= 2'd0;
                    r_halted <= 1'b0;
                    r_wait   <= 4'd0;
                end
            endcase
        end
    end

`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
    logic [15:0] r_retired;

    // Retired-instruction count; halts never reach pc_advance so they are not counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_retired <= 16'd0;
        end else if (w_pc_advance) begin
            r_retired <= r_retired + 16'd1;
        end else begin
            r_retired <= r_retired;
        end
    end

    assign retired = r_retired;
`endif

    assign step           = r_step;
    assign halted         = r_halted;
    assign bus_error      = r_bus_error;
    assign mem_read       = w_mem_read;
    assign mem_write      = w_mem_write;
    assign address_select = w_addr_sel;
    assign pc_advance     = w_pc_advance;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: constant vector table, hand-written corner sequences,
// and randomized stimulus against a per-instruction behavioural model.
module tb_instruction_sequencer;

    localparam int WAIT_LIMIT = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        resume = 1'b0;
    logic        mem_ready = 1'b0;
    logic        halt_request = 1'b0;
    logic        can_halt = 1'b0;
    logic        source_mem = 1'b0;
    logic        destination_mem = 1'b0;
    logic        write_enable = 1'b0;
    logic [1:0]  step;
    logic [1:0]  address_select;
    logic        mem_read;
    logic        mem_write;
    logic        pc_advance;
    logic        halted;
    logic        bus_error;
`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
    logic [15:0] retired;
`endif

    instruction_sequencer #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .run(run),
        .resume(resume),
        .mem_ready(mem_ready),
        .halt_request(halt_request),
        .can_halt(can_halt),
        .source_mem(source_mem),
        .destination_mem(destination_mem),
        .write_enable(write_enable),
        .step(step),
        .address_select(address_select),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .pc_advance(pc_advance),
        .halted(halted),
        .bus_error(bus_error)
`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
        ,
        .retired(retired)
`endif
    );

    always #5 clock = ~clock;

    // {step, address_select, mem_read, mem_write, pc_advance, halted, bus_error}
    logic [8:0] act;
    assign act = {step, address_select, mem_read, mem_write, pc_advance, halted, bus_error};

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 running an instruction, 2 halted, 3 bus error.
    int m_mode, m_step, m_wait, m_retired;

    typedef struct packed {
        logic [7:0] in;   // {run, ready, halt_request, can_halt, source_mem, destination_mem, write_enable, resume}
        logic [8:0] exp;
    } vec_t;
    vec_t tbl [0:28];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic apply(input logic [7:0] v);
        @(posedge clock);
        #1;
        {run, mem_ready, halt_request, can_halt, source_mem, destination_mem, write_enable, resume} = v;
        #3;
    endtask

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_wait = 0; m_retired = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {run, mem_ready, halt_request, can_halt, source_mem, destination_mem, write_enable, resume} = 8'h00;
        @(posedge clock);
        #1;
        check("reset_state", 32'(act), 32'd0);
`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
        check("reset_retired", 32'(retired), 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Expected outputs: the address source always matches the step while an instruction runs.
    task automatic model_out(input logic [7:0] v, output logic [8:0] e, output logic halt);
        logic rd, wr, pa;
        int st;
        rd = 1'b0; wr = 1'b0; pa = 1'b0; halt = 1'b0; st = 0;
        if (m_mode == 1) begin
            st   = m_step;
            halt = (m_step == 2) && v[5] && v[4];
            rd   = (m_step < 2) || ((m_step == 2) && v[3] && !halt);
            wr   = (m_step == 3) && v[2] && v[1];
            pa   = (m_step == 3) && (!wr || v[6]);
        end
        e = {2'(st), 2'(st), rd, wr, pa, 1'(m_mode == 2), 1'(m_mode == 3)};
    endtask

    task automatic model_step(input logic [7:0] v);
        logic [8:0] e;
        logic halt;
        model_out(v, e, halt);
        case (m_mode)
            0: if (v[7]) begin m_mode = 1; m_step = 0; m_wait = 0; end
            1: begin
                if (halt) begin
                    m_mode = 2;
                end else if ((e[4] || e[3]) && !v[6]) begin
                    m_wait++;
                    if (m_wait >= WAIT_LIMIT) m_mode = 3;
                end else begin
                    if (e[2]) m_retired = (m_retired + 1) % 65536;
                    m_wait = 0;
                    if (m_step == 3) begin
                        m_step = 0;
                        m_mode = v[7] ? 1 : 0;
                    end else begin
                        m_step++;
                    end
                end
            end
            2: if (v[0]) m_mode = 0;
            default: ;
        endcase
    endtask

    initial begin
        logic [7:0] v;
        logic [8:0] e;
        logic       h;

        tbl[0]  = '{8'b1_1_0_0_0_0_0_0, 9'b00_00_0_0_0_0_0};
        tbl[1]  = '{8'b1_1_0_0_0_0_0_0, 9'b00_00_1_0_0_0_0};
        tbl[2]  = '{8'b1_1_0_0_0_0_0_0, 9'b01_01_1_0_0_0_0};
        tbl[3]  = '{8'b1_1_0_0_0_0_0_0, 9'b10_10_0_0_0_0_0};
        tbl[4]  = '{8'b1_1_0_0_0_0_0_0, 9'b11_11_0_0_1_0_0};
        tbl[5]  = '{8'b1_1_0_0_0_0_0_0, 9'b00_00_1_0_0_0_0};
        tbl[6]  = '{8'b1_0_0_0_0_0_0_0, 9'b01_01_1_0_0_0_0};
        tbl[7]  = '{8'b1_0_0_0_0_0_0_0, 9'b01_01_1_0_0_0_0};
        tbl[8]  = '{8'b1_1_0_0_0_0_0_0, 9'b01_01_1_0_0_0_0};
        tbl[9]  = '{8'b1_0_0_0_1_0_0_0, 9'b10_10_1_0_0_0_0};
        tbl[10] = '{8'b1_1_0_0_1_0_0_0, 9'b10_10_1_0_0_0_0};
        tbl[11] = '{8'b1_0_0_0_0_1_1_0, 9'b11_11_0_1_0_0_0};
        tbl[12] = '{8'b1_1_0_0_0_1_1_0, 9'b11_11_0_1_1_0_0};
        tbl[13] = '{8'b0_1_0_0_0_0_0_0, 9'b00_00_1_0_0_0_0};
        tbl[14] = '{8'b0_1_0_0_0_0_0_0, 9'b01_01_1_0_0_0_0};
        tbl[15] = '{8'b0_1_0_0_0_0_0_0, 9'b10_10_0_0_0_0_0};
        tbl[16] = '{8'b0_1_0_0_0_1_0_0, 9'b11_11_0_0_1_0_0};
        tbl[17] = '{8'b0_1_0_0_0_0_0_0, 9'b00_00_0_0_0_0_0};
        tbl[18] = '{8'b1_1_0_0_0_0_0_1, 9'b00_00_0_0_0_0_0};
        tbl[19] = '{8'b1_1_0_0_0_0_0_0, 9'b00_00_1_0_0_0_0};
        tbl[20] = '{8'b1_1_0_0_0_0_0_0, 9'b01_01_1_0_0_0_0};
        tbl[21] = '{8'b1_1_1_1_1_0_0_0, 9'b10_10_0_0_0_0_0};
        tbl[22] = '{8'b1_1_0_0_0_0_0_0, 9'b00_00_0_0_0_1_0};
        tbl[23] = '{8'b1_1_0_0_0_0_0_1, 9'b00_00_0_0_0_1_0};
        tbl[24] = '{8'b1_1_0_0_0_0_0_0, 9'b00_00_0_0_0_0_0};
        tbl[25] = '{8'b1_1_0_0_0_0_0_0, 9'b00_00_1_0_0_0_0};
        tbl[26] = '{8'b1_1_0_0_0_0_0_0, 9'b01_01_1_0_0_0_0};
        tbl[27] = '{8'b1_1_1_0_0_0_0_0, 9'b10_10_0_0_0_0_0};
        tbl[28] = '{8'b1_1_0_0_0_0_0_0, 9'b11_11_0_0_1_0_0};

        // Vector table: zero-wait loop, waits in IMM/READ/WRITE, run drop, halt/resume, non-halt.
        do_reset();
        for (int i = 0; i <= 28; i++) begin
            apply(tbl[i].in);
            check($sformatf("table_row%0d", i), 32'(act), 32'(tbl[i].exp));
        end

        // Write step with 14 wait cycles completes; the next with 15 trips the bus error.
        do_reset();
        repeat (4) apply(8'b1_1_0_0_0_0_0_0);
        repeat (14) apply(8'b1_0_0_0_0_1_1_0);
        check("wait14_no_error", 32'(act), 32'(9'b11_11_0_1_0_0_0));
        apply(8'b1_1_0_0_0_1_1_0);
        check("wait14_then_ready", 32'(act), 32'(9'b11_11_0_1_1_0_0));
        repeat (3) apply(8'b1_1_0_0_0_0_0_0);
        repeat (15) apply(8'b1_0_0_0_0_1_1_0);
        apply(8'b1_1_0_0_0_1_1_0);
        check("bus_error_set", 32'(act), 32'(9'b00_00_0_0_0_0_1));
        repeat (3) apply(8'b1_1_0_0_0_0_0_1);
        check("bus_error_sticky", 32'(act), 32'(9'b00_00_0_0_0_0_1));

        // Reset asserted mid-WRITE kills the write strobe and pc_advance at once.
        do_reset();
        repeat (5) apply(8'b1_1_0_0_0_0_0_0);
        repeat (3) apply(8'b1_1_0_0_0_0_0_0);
        apply(8'b1_0_0_0_0_1_1_0);
        check("pre_reset_write", 32'(act), 32'(9'b11_11_0_1_0_0_0));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_write", 32'(act), 32'd0);
`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
        check("async_reset_retired", 32'(retired), 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
        // Three instructions then a halt: only the three are counted.
        do_reset();
        repeat (13) apply(8'b1_1_0_0_0_0_0_0);
        repeat (2) apply(8'b1_1_0_0_0_0_0_0);
        apply(8'b1_1_1_1_0_0_0_0);
        apply(8'b1_1_0_0_0_0_0_0);
        check("retired_after_halt", 32'(retired), 32'd3);
        check("halted_after_three", 32'(halted), 32'd1);
`endif

        // Randomized stimulus against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v[7] = ($urandom_range(0, 9) != 0);
            v[6] = (c < 1500) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 4);
            v[5] = ($urandom_range(0, 3) == 0);
            v[4] = 1'($urandom_range(0, 1));
            v[3] = 1'($urandom_range(0, 1));
            v[2] = 1'($urandom_range(0, 1));
            v[1] = 1'($urandom_range(0, 1));
            v[0] = ($urandom_range(0, 4) == 0);
            apply(v);
            model_out(v, e, h);
            check("random_outputs", 32'(act), 32'(e));
`ifdef INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN
            check("random_retired", 32'(retired), 32'(m_retired));
`endif
            model_step(v);
            if (m_mode == 3) begin
                apply(8'h00);
                check("random_bus_error", 32'(act), 32'(9'b00_00_0_0_0_0_1));
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Four-step instruction sequencer for the uCISC core. It drives the shared `step` bus that the loaders, value captures and execute units key off. It also owns the single memory port's read/write strobes and address-source select, stretching each step across memory wait states, and it handles halt detection and run/resume control. It sits between the memory interface and the fetch/immediate/execute datapath.

## Interface
Parameters:
- `WAIT_LIMIT`, 15: maximum wait cycles per memory step before `bus_error` (4-bit counter width fixed).

Ports:
- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `run`  in  1  level; 1 = start/continue instructions, 0 = stop after current instruction
- `resume`  in  1  single-cycle pulse; leaves HALTED
- `mem_ready`  in  1  memory completed the strobed access this cycle
- `halt_request`  in  1  decoded instruction is halt-class (valid from step 1 onward)
- `can_halt`  in  1  captured immediate is zero (valid from step 2 onward)
- `source_mem`  in  1  instruction reads a memory source operand
- `destination_mem`  in  1  destination is memory (else register)
- `write_enable`  in  1  condition passed; result is committed
- `step`  out  2  current step: 0 fetch, 1 immediate, 2 read, 3 write
- `address_select`  out  2  0 pc, 1 pc+1, 2 source address, 3 destination address
- `mem_read`  out  1  read strobe
- `mem_write`  out  1  write strobe
- `pc_advance`  out  1  pc updates at this clock edge
- `halted`  out  1  core halted
- `bus_error`  out  1  sticky; memory step exceeded `WAIT_LIMIT`

## Operation
- States: IDLE, FETCH, IMM, READ, WRITE, HALTED, ERROR. `step` = 0 in IDLE/FETCH/HALTED/ERROR, 1 in IMM, 2 in READ, 3 in WRITE.
- IDLE: strobes 0. Enters FETCH when `run`=1.
- FETCH: `mem_read`=1, `address_select`=0. Goes to IMM on `mem_ready`.
- IMM: `mem_read`=1, `address_select`=1. Goes to READ on `mem_ready`. Capture units sample every cycle of their step; the `mem_ready` cycle sample is final.
- READ: if `halt_request` && `can_halt`, go to HALTED with no write and no `pc_advance`. Otherwise, if `source_mem`=1, assert `mem_read` with `address_select`=2 and go to WRITE on `mem_ready`. If `source_mem`=0, no strobe and go to WRITE after 1 cycle.
- WRITE: `address_select`=3. With `destination_mem` && `write_enable`, assert `mem_write` and wait for `mem_ready`. Otherwise the step takes 1 cycle with no strobe. `pc_advance`=1 in the final WRITE cycle. Then go to FETCH if `run`=1, else IDLE.
- HALTED: `halted`=1, strobes 0. A `resume` pulse goes to IDLE. `pc` is not advanced, so the halt instruction re-executes unless software changes `pc`.
- Wait counter: cleared on every step entry, increments each strobed cycle without `mem_ready`. When it reaches `WAIT_LIMIT`, go to ERROR and set `bus_error`=1. ERROR holds until `reset`.
- `run` falling mid-instruction: the instruction completes and the sequencer then parks in IDLE.
- `resume` outside HALTED: ignored.

## Timing
- Reset values: state IDLE, `step`=0, `address_select`=0, `mem_read`=0, `mem_write`=0, `pc_advance`=0, `halted`=0, `bus_error`=0, wait counter 0.
- `step`, `halted` and `bus_error` are registered. Strobes, `address_select` and `pc_advance` decode combinationally from state and inputs.
- Zero-wait instruction: 4 cycles, FETCH→IMM→READ→WRITE, back-to-back with no bubble.
- IDLE→FETCH costs 1 cycle after `run` is sampled high.
- Each memory wait cycle adds exactly 1 cycle to its step.
- `mem_ready` is only meaningful while a strobe is asserted and is ignored otherwise.
- Reset asserted mid-step aborts the step immediately (asynchronously). No `pc_advance` or `mem_write` occurs after reset is asserted.

## Configuration
- `INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN`, when defined:
  - adds output `retired` (16 bits, reset 0);
  - `retired` increments on every `pc_advance`, wrapping 0xFFFF→0;
  - halted instructions are not counted.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset, then `run`=1 with `mem_ready` tied 1 and no `source_mem`/`destination_mem` → `step` sequence 0,1,2,3,0,… with a period of 4. `pc_advance` pulses once per 4 cycles.
- `mem_ready` low for 2 cycles in IMM → `step`=1 held for 3 cycles with `mem_read`=1 and `address_select`=1. The immediate captured is the value on the third (ready) cycle.
- `halt_request`=1, `can_halt`=1 in READ → `halted`=1 next cycle, no `pc_advance`, no `mem_write`. A `resume` pulse returns to IDLE, then FETCH.
- `destination_mem`=1, `write_enable`=1, `mem_ready`=0 for 15 cycles in WRITE → `bus_error`=1, strobes drop to 0, state sticks until `reset`.
- `run` dropped during IMM → the instruction finishes through WRITE with `pc_advance`, then `step`=0 and `mem_read`=0 in IDLE.
- With `INSTRUCTION_SEQUENCER_RETIRE_COUNT_EN`: 3 instructions then a halt → `retired`=3. Reset mid-WRITE → `retired`=0 and no extra increment.
